uart_tx: RTL
============

# uart_tx

Serial transmitter that drains the byte FIFO and sends each entry as an asynchronous UART frame: start bit, data LSB-first, optional parity bit, one stop bit. It sits directly downstream of `fifo` on the transmit path. It pops one entry whenever it is idle and the FIFO is non-empty, then drives the `tx` pin.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; must match the FIFO data width.
- `CLKS_PER_BIT`, 104: clock cycles per serial bit (12 MHz / 115200); must be at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO `empty` flag.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`.
- `fifo_rd`  out  1  FIFO `rd` strobe.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Reset values while `reset`=0: `tx`=1, `fifo_rd`=0, `busy`=0, state IDLE, all counters 0.
- States and transitions:
  - IDLE: if `fifo_empty`=0, go to FETCH; otherwise stay.
  - FETCH: `fifo_rd`=1 for exactly this one cycle; go to LOAD.
  - LOAD: capture `fifo_data` into the shift register; go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles; go to DATA.
  - DATA: shift out DATA_WIDTH bits, LSB first, each for CLKS_PER_BIT cycles; go to PARITY if compiled in, otherwise STOP.
  - PARITY: see Configuration.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles; go to IDLE.
- `fifo_rd` is asserted only in FETCH, so there is exactly one pop per frame. The FIFO data output is valid one cycle after `rd` is sampled, which is why LOAD takes one cycle.
- `tx` is registered and glitch-free. `fifo_rd` and `busy` are decoded from the state register.
- Counters:
  - Bit-period counter: width `$clog2(CLKS_PER_BIT)`; counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
  - Bit index: width `$clog2(DATA_WIDTH)`, minimum 1; counts 0..DATA_WIDTH-1.
- Boundary conditions:
  - `fifo_empty` rising during FETCH, LOAD or a frame has no effect on the current frame.
  - `fifo_empty` is sampled only in IDLE.
  - Reset asserted mid-frame: `tx` goes to 1 immediately and asynchronously. The fetched byte is discarded; no extra `fifo_rd` is issued.
  - Reset asserted during FETCH: `fifo_rd` drops at once.
  - After reset is released, operation restarts from IDLE.

## Timing
- Let E0 be the rising edge at which IDLE samples `fifo_empty`=0.
  - FETCH occupies the cycle after E0; the FIFO pops at E1.
  - The shift register loads at E2, and `tx` falls at E2.
- Frame length on the line: (DATA_WIDTH+2)·CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back frames: `tx` stays high for CLKS_PER_BIT+3 cycles between a stop bit and the next start bit (STOP, then IDLE, FETCH and LOAD at 1 cycle each).
- Throughput: one FIFO entry per frame.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state follows DATA. `tx` is the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles, then STOP.
- Undefined: no PARITY state and no parity logic; DATA goes directly to STOP.

## Test plan
Bench setup: `fifo` with DEPTH 4, DATA_WIDTH 8, CLKS_PER_BIT 4, feeding `uart_tx`; a bench UART decoder samples `tx` at bit centres.
- Reset held 3 cycles, then released with the FIFO empty -> `tx`=1, `busy`=0, `fifo_rd`=0 for the next 100 cycles.
- Write 0xA5 -> one `fifo_rd` pulse; `tx` low 2 cycles after the pulse cycle; line bits 0,1,0,1,0,0,1,0,1,1; frame 40 cycles; `busy` then drops.
- Write 0x00..0x03 on consecutive cycles -> exactly 4 `fifo_rd` pulses; decoder yields 0,1,2,3 in order; each inter-frame high gap is 7 cycles; `empty`=1 after the 4th pop.
- Write 0x3C and 0x81, then pull `reset` low in the middle of data bit 3 of the first frame -> `tx`=1 and `busy`=0 in the same cycle. After release, a single pop occurs and 0x81 is transmitted completely.
- With `UART_TX_PARITY_EN`: write 0x07 -> parity bit 1 and frame 44 cycles; write 0x03 -> parity bit 0.
- Without the macro: write 0x07 -> stop bit directly follows data bit 7; frame 40 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmitter: pops one byte per frame from the upstream FIFO and sends start, data LSB-first,
// optional even parity and one stop bit. Define UART_TX_PARITY_EN to include the parity bit.
module uart_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign bit_done = (cnt_q == CntLast);
  assign tx       = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    fifo_rd = 1'b0;
    busy    = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        idx_d = '0;
        // fifo_empty is only looked at here; later changes cannot disturb a frame
        if (!fifo_empty) state_d = StFetch;
      end
      StFetch: begin
        fifo_rd = 1'b1;
        state_d = StLoad;
      end
      StLoad: begin
        // FIFO output is valid the cycle after the pop
        shift_d = fifo_data;
`ifdef UART_TX_PARITY_EN
        parity_d = ^fifo_data;
`endif
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        if (bit_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == IdxLast) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_done) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
